// File: rtl/cache_pkg.sv
// Shared types and constants for the cache fill arbiter.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_t;

  typedef enum logic {
    SIDE_I = 1'b0,
    SIDE_D = 1'b1
  } side_t;

  localparam int WORDS_PER_BLOCK   = 8;
  localparam int BLOCK_OFFSET_BITS = 4;

  // Align a byte address down to the start of its cache block.
  function automatic logic [15:0] block_base(input logic [15:0] addr);
    return addr & ~((16'd1 << BLOCK_OFFSET_BITS) - 16'd1);
  endfunction

endpackage

// File: rtl/word_counter.sv
// Small wrapping up-counter with synchronous clear and count enable.
module word_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  // Count enabled events; clear takes priority over enable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/cache_fill_arbiter.sv
// Arbitrates I-cache misses, D-cache misses and D-side write-through stores
// onto a single main-memory port, and streams returning block data into the
// requesting cache's data array.
module cache_fill_arbiter
  import cache_pkg::*;
#(
  parameter int MEM_LATENCY = 4,
  parameter int WORDS       = WORDS_PER_BLOCK
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_miss,
  input  logic [15:0] i_miss_addr,
  input  logic        d_miss,
  input  logic [15:0] d_miss_addr,
  input  logic        d_wr,
  input  logic [15:0] d_wr_addr,
  input  logic [15:0] d_wr_data,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_valid,
  output logic        fill_i_we,
  output logic        fill_d_we,
  output logic [2:0]  fill_word,
  output logic [15:0] fill_data,
  output logic        tag_i_we,
  output logic        tag_d_we,
  output logic        i_done,
  output logic        d_done,
  output logic        wr_done,
  output logic        busy
);

  localparam int CW = $clog2(WORDS);

  // Words are 16-bit, so a block of WORDS words must fit in the offset field.
  if (MEM_LATENCY < 1) begin : g_bad_latency
    $error("MEM_LATENCY must be at least 1");
  end
  if ((2 * WORDS) != (1 << BLOCK_OFFSET_BITS)) begin : g_bad_words
    $error("WORDS must fill exactly one block of 2**BLOCK_OFFSET_BITS bytes");
  end

  state_t          r_state;
  state_t          w_next;
  side_t           r_last_grant;
  side_t           r_target;
  logic [15:0]     r_base;
  logic            r_issue_done;

  logic [CW-1:0]   w_issue_cnt;
  logic [CW-1:0]   w_rcv_cnt;
  logic            w_d_req;
  logic            w_i_req;
  logic            w_pick_d;
  logic            w_pick_i;
  logic            w_in_fill;
  logic            w_last_word;
  logic [BLOCK_OFFSET_BITS-1:0] w_offs;

  assign w_in_fill   = (r_state == FILL);
  assign w_last_word = (w_rcv_cnt == CW'(WORDS - 1));
  assign w_offs      = BLOCK_OFFSET_BITS'({w_issue_cnt, 1'b0});

  word_counter #(.WIDTH(CW)) u_issue_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (!w_in_fill),
    .i_en    (w_in_fill && !r_issue_done),
    .o_count (w_issue_cnt)
  );

  word_counter #(.WIDTH(CW)) u_rcv_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (!w_in_fill),
    .i_en    (w_in_fill && mem_valid),
    .o_count (w_rcv_cnt)
  );

  // Round-robin between sides on contention; D side folds miss and store.
  always_comb begin
    w_d_req  = d_miss || d_wr;
    w_i_req  = i_miss;
    w_pick_d = w_d_req && (!w_i_req || (r_last_grant == SIDE_I));
    w_pick_i = w_i_req && !w_pick_d;
  end

  // State, grant history, latched block base/target and issue-complete flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last_grant <= SIDE_I;
      r_target     <= SIDE_I;
      r_base       <= '0;
      r_issue_done <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE) begin
        if (w_pick_d) begin
          r_last_grant <= SIDE_D;
          if (d_miss) begin
            r_base   <= block_base(d_miss_addr);
            r_target <= SIDE_D;
          end
        end else if (w_pick_i) begin
          r_last_grant <= SIDE_I;
          r_base       <= block_base(i_miss_addr);
          r_target     <= SIDE_I;
        end
      end
      // Issue stops once the last word's read has gone out.
      if (!w_in_fill) begin
        r_issue_done <= 1'b0;
      end else if (!r_issue_done && (w_issue_cnt == CW'(WORDS - 1))) begin
        r_issue_done <= 1'b1;
      end
    end
  end

  // Next-state selection and all memory/fill/tag/done outputs.
  always_comb begin
    w_next    = r_state;
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    fill_i_we = 1'b0;
    fill_d_we = 1'b0;
    fill_word = '0;
    fill_data = '0;
    tag_i_we  = 1'b0;
    tag_d_we  = 1'b0;
    i_done    = 1'b0;
    d_done    = 1'b0;
    wr_done   = 1'b0;
    busy      = (r_state != IDLE);

    case (r_state)
      IDLE: begin
        if (w_pick_d) begin
          w_next = d_miss ? FILL : WRITE;
        end else if (w_pick_i) begin
          w_next = FILL;
        end
      end

      FILL: begin
        if (!r_issue_done) begin
          mem_en   = 1'b1;
          mem_addr = r_base | 16'(w_offs);
        end
        if (mem_valid) begin
          fill_i_we = (r_target == SIDE_I);
          fill_d_we = (r_target == SIDE_D);
          fill_word = 3'(w_rcv_cnt);
          fill_data = mem_rdata;
          if (w_last_word) begin
            tag_i_we = (r_target == SIDE_I);
            tag_d_we = (r_target == SIDE_D);
            i_done   = (r_target == SIDE_I);
            d_done   = (r_target == SIDE_D);
            w_next   = IDLE;
          end
        end
      end

      WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = d_wr_addr;
        mem_wdata = d_wr_data;
        wr_done   = 1'b1;
        w_next    = IDLE;
      end

      default: begin
        w_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Directed bench for cache_fill_arbiter with a fixed-latency memory model.
module tb_cache_fill_arbiter;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_miss;
  logic [15:0] i_miss_addr;
  logic        d_miss;
  logic [15:0] d_miss_addr;
  logic        d_wr;
  logic [15:0] d_wr_addr;
  logic [15:0] d_wr_data;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_valid;
  logic        fill_i_we;
  logic        fill_d_we;
  logic [2:0]  fill_word;
  logic [15:0] fill_data;
  logic        tag_i_we;
  logic        tag_d_we;
  logic        i_done;
  logic        d_done;
  logic        wr_done;
  logic        busy;

  logic        stray;
  logic [15:0] stray_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cache_fill_arbiter #(.MEM_LATENCY(LAT), .WORDS(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_miss      (i_miss),
    .i_miss_addr (i_miss_addr),
    .d_miss      (d_miss),
    .d_miss_addr (d_miss_addr),
    .d_wr        (d_wr),
    .d_wr_addr   (d_wr_addr),
    .d_wr_data   (d_wr_data),
    .mem_en      (mem_en),
    .mem_wr      (mem_wr),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_valid   (mem_valid),
    .fill_i_we   (fill_i_we),
    .fill_d_we   (fill_d_we),
    .fill_word   (fill_word),
    .fill_data   (fill_data),
    .tag_i_we    (tag_i_we),
    .tag_d_we    (tag_d_we),
    .i_done      (i_done),
    .d_done      (d_done),
    .wr_done     (wr_done),
    .busy        (busy)
  );

  // Memory model: every read returns LAT cycles after issue, data = addr + 0x1000.
  logic [LAT-1:0] vpipe = '0;
  logic [15:0]    apipe [LAT];

  always @(posedge clk) begin
    vpipe    <= {vpipe[LAT-2:0], mem_en & ~mem_wr};
    apipe[0] <= mem_addr;
    for (int k = 1; k < LAT; k++) apipe[k] <= apipe[k-1];
  end

  assign mem_valid = vpipe[LAT-1] | stray;
  assign mem_rdata = stray ? stray_data : (apipe[LAT-1] + 16'h1000);

  typedef struct {
    logic        im;
    logic        en;
    logic [15:0] addr;
    logic        fwe;
    logic [2:0]  fw;
    logic [15:0] fd;
    logic        tag;
    logic        done;
    logic        bsy;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic quiet(input string tag);
    chk({tag, " mem_en"},    16'(mem_en),    16'h0);
    chk({tag, " mem_wr"},    16'(mem_wr),    16'h0);
    chk({tag, " mem_addr"},  mem_addr,       16'h0);
    chk({tag, " mem_wdata"}, mem_wdata,      16'h0);
    chk({tag, " fill_i_we"}, 16'(fill_i_we), 16'h0);
    chk({tag, " fill_d_we"}, 16'(fill_d_we), 16'h0);
    chk({tag, " fill_word"}, 16'(fill_word), 16'h0);
    chk({tag, " fill_data"}, fill_data,      16'h0);
    chk({tag, " tag_i_we"},  16'(tag_i_we),  16'h0);
    chk({tag, " tag_d_we"},  16'(tag_d_we),  16'h0);
    chk({tag, " i_done"},    16'(i_done),    16'h0);
    chk({tag, " d_done"},    16'(d_done),    16'h0);
    chk({tag, " wr_done"},   16'(wr_done),   16'h0);
    chk({tag, " busy"},      16'(busy),      16'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // I miss at 0x0126: {i_miss, mem_en, mem_addr, fill_i_we, word, data, tag, done, busy}
    tbl[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 16'h0120, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 1'b1, 16'h0122, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 16'h0124, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 1'b1, 16'h0126, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 1'b1, 16'h0128, 1'b1, 3'd0, 16'h1120, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, 16'h012A, 1'b1, 3'd1, 16'h1122, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, 16'h012C, 1'b1, 3'd2, 16'h1124, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, 16'h012E, 1'b1, 3'd3, 16'h1126, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 3'd4, 16'h1128, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 16'h0000, 1'b1, 3'd5, 16'h112A, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 16'h0000, 1'b1, 3'd6, 16'h112C, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 16'h0000, 1'b1, 3'd7, 16'h112E, 1'b1, 1'b1, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0; i_miss = 1'b0; i_miss_addr = '0; d_miss = 1'b0; d_miss_addr = '0;
    d_wr = 1'b0; d_wr_addr = '0; d_wr_data = '0; stray = 1'b0; stray_data = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    smp();
    quiet("reset");
    step();

    // I miss alone, table driven.
    for (int r = 0; r < 14; r++) begin
      i_miss      = tbl[r].im;
      i_miss_addr = 16'h0126;
      smp();
      chk($sformatf("s1[%0d] mem_en", r),    16'(mem_en),    16'(tbl[r].en));
      chk($sformatf("s1[%0d] mem_wr", r),    16'(mem_wr),    16'h0);
      chk($sformatf("s1[%0d] mem_addr", r),  mem_addr,       tbl[r].addr);
      chk($sformatf("s1[%0d] fill_i_we", r), 16'(fill_i_we), 16'(tbl[r].fwe));
      chk($sformatf("s1[%0d] fill_d_we", r), 16'(fill_d_we), 16'h0);
      chk($sformatf("s1[%0d] fill_word", r), 16'(fill_word), 16'(tbl[r].fw));
      chk($sformatf("s1[%0d] fill_data", r), fill_data,      tbl[r].fd);
      chk($sformatf("s1[%0d] tag_i_we", r),  16'(tag_i_we),  16'(tbl[r].tag));
      chk($sformatf("s1[%0d] tag_d_we", r),  16'(tag_d_we),  16'h0);
      chk($sformatf("s1[%0d] i_done", r),    16'(i_done),    16'(tbl[r].done));
      chk($sformatf("s1[%0d] d_done", r),    16'(d_done),    16'h0);
      chk($sformatf("s1[%0d] busy", r),      16'(busy),      16'(tbl[r].bsy));
      step();
    end

    // Stray mem_valid while idle.
    stray = 1'b1; stray_data = 16'hDEAD;
    smp();
    quiet("stray");
    step();
    stray = 1'b0;
    step();

    // I miss dropped at T+3: fill still completes.
    for (int c = 0; c <= 13; c++) begin
      i_miss = (c < 3); i_miss_addr = 16'h0126;
      smp();
      if (c == 11) chk("drop i_done@11", 16'(i_done), 16'h0);
      if (c == 12) begin
        chk("drop fill_i_we@12", 16'(fill_i_we), 16'h1);
        chk("drop fill_word@12", 16'(fill_word), 16'h7);
        chk("drop fill_data@12", fill_data,      16'h112E);
        chk("drop tag_i_we@12",  16'(tag_i_we),  16'h1);
        chk("drop i_done@12",    16'(i_done),    16'h1);
      end
      if (c == 13) chk("drop busy@13", 16'(busy), 16'h0);
      step();
    end

    // Reset mid-fill at T+6; late returns must be ignored.
    for (int c = 0; c <= 13; c++) begin
      i_miss = (c < 7); i_miss_addr = 16'h0126;
      rst_n  = (c != 6);
      smp();
      if (c == 5) chk("rst fill_i_we@5", 16'(fill_i_we), 16'h1);
      if (c >= 7) quiet($sformatf("rst@%0d", c));
      step();
    end
    rst_n = 1'b1;

    // Simultaneous D and I misses after reset: D first, then I.
    for (int c = 0; c <= 26; c++) begin
      d_miss = (c <= 12); d_miss_addr = 16'h4002;
      i_miss = (c <= 25); i_miss_addr = 16'h0010;
      smp();
      if (c == 1) begin
        chk("arb mem_en@1",   16'(mem_en), 16'h1);
        chk("arb mem_addr@1", mem_addr,    16'h4000);
      end
      if (c == 5) begin
        chk("arb fill_d_we@5", 16'(fill_d_we), 16'h1);
        chk("arb fill_i_we@5", 16'(fill_i_we), 16'h0);
      end
      if (c == 12) begin
        chk("arb d_done@12",    16'(d_done),    16'h1);
        chk("arb tag_d_we@12",  16'(tag_d_we),  16'h1);
        chk("arb i_done@12",    16'(i_done),    16'h0);
        chk("arb fill_word@12", 16'(fill_word), 16'h7);
        chk("arb fill_data@12", fill_data,      16'h500E);
      end
      if (c == 13) chk("arb busy@13", 16'(busy), 16'h0);
      if (c == 14) begin
        chk("arb mem_en@14",   16'(mem_en), 16'h1);
        chk("arb mem_addr@14", mem_addr,    16'h0010);
      end
      if (c == 18) begin
        chk("arb fill_i_we@18", 16'(fill_i_we), 16'h1);
        chk("arb fill_data@18", fill_data,      16'h1010);
      end
      if (c == 25) begin
        chk("arb i_done@25",    16'(i_done),    16'h1);
        chk("arb tag_i_we@25",  16'(tag_i_we),  16'h1);
        chk("arb fill_word@25", 16'(fill_word), 16'h7);
        chk("arb fill_data@25", fill_data,      16'h101E);
      end
      if (c == 26) chk("arb busy@26", 16'(busy), 16'h0);
      step();
    end

    // D miss plus store held together: fill first, then the write cycle.
    for (int c = 0; c <= 15; c++) begin
      d_miss = (c <= 12); d_miss_addr = 16'h4002;
      d_wr   = (c <= 14); d_wr_addr = 16'h4002; d_wr_data = 16'hBEEF;
      smp();
      if (c == 1) chk("wr mem_wr@1", 16'(mem_wr), 16'h0);
      if (c == 12) begin
        chk("wr d_done@12",  16'(d_done),  16'h1);
        chk("wr wr_done@12", 16'(wr_done), 16'h0);
      end
      if (c == 13) begin
        chk("wr busy@13",   16'(busy),   16'h0);
        chk("wr mem_en@13", 16'(mem_en), 16'h0);
      end
      if (c == 14) begin
        chk("wr mem_en@14",    16'(mem_en),    16'h1);
        chk("wr mem_wr@14",    16'(mem_wr),    16'h1);
        chk("wr mem_addr@14",  mem_addr,       16'h4002);
        chk("wr mem_wdata@14", mem_wdata,      16'hBEEF);
        chk("wr wr_done@14",   16'(wr_done),   16'h1);
        chk("wr busy@14",      16'(busy),      16'h1);
        chk("wr fill_d_we@14", 16'(fill_d_we), 16'h0);
      end
      if (c == 15) quiet("wr@15");
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
